// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle ADD/SUB/OR/LUI, iterative 1-bit-per-cycle SLL/SRL.
// Define ALU_FAST_SHIFT_EN to replace the iterative shifter with a single-cycle barrel shifter.
module alu_exec_unit #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_data_i,
    input  logic [DATA_WIDTH-1:0]  b_data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic [DATA_WIDTH-1:0]  result_o,
    output logic                   zero_o,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   illegal_o
);

    localparam logic [3:0] OpLui = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpSll = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSrl = 4'b0100;
    localparam logic [3:0] OpSub = 4'b0101;
    localparam int unsigned HalfWidth = DATA_WIDTH / 2;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;
    logic                  zero_q, zero_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] op_result;
    logic                  op_illegal;
    logic                  op_is_shift;

`ifndef ALU_FAST_SHIFT_EN
    logic [DATA_WIDTH-1:0]  shreg_q, shreg_d, shreg_next;
    logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
    logic                   left_q, left_d;
`endif

    // Single-cycle result for the op on the inputs; iterative shifts only use op_is_shift.
    always_comb begin
        op_result   = '0;
        op_illegal  = 1'b0;
        op_is_shift = 1'b0;
        case (alu_operation_i)
            OpLui: op_result = {b_data_i[HalfWidth-1:0], {HalfWidth{1'b0}}};
            OpOr:  op_result = a_data_i | b_data_i;
            OpAdd: op_result = a_data_i + b_data_i;
            OpSub: op_result = a_data_i - b_data_i;
`ifdef ALU_FAST_SHIFT_EN
            OpSll: op_result = b_data_i << shamt_i;
            OpSrl: op_result = b_data_i >> shamt_i;
`else
            OpSll, OpSrl: begin
                op_result   = b_data_i;
                op_is_shift = (shamt_i != '0);
            end
`endif
            default: op_illegal = 1'b1;
        endcase
    end

`ifndef ALU_FAST_SHIFT_EN
    assign shreg_next = left_q ? (shreg_q << 1) : (shreg_q >> 1);
`endif

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        zero_d    = zero_q;
        illegal_d = illegal_q;
`ifndef ALU_FAST_SHIFT_EN
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
`endif
        case (state_q)
            StShift: begin
`ifndef ALU_FAST_SHIFT_EN
                shreg_d = shreg_next;
                cnt_d   = cnt_q - SHAMT_WIDTH'(1);
                if (cnt_q == SHAMT_WIDTH'(1)) begin
                    result_d  = shreg_next;
                    zero_d    = (shreg_next == '0);
                    illegal_d = 1'b0;
                    state_d   = StDone;
                end
`else
                state_d = StIdle;
`endif
            end
            default: begin
                state_d = StIdle;
                if (start_i) begin
                    if (op_is_shift) begin
`ifndef ALU_FAST_SHIFT_EN
                        shreg_d = b_data_i;
                        cnt_d   = shamt_i;
                        left_d  = (alu_operation_i == OpSll);
`endif
                        state_d = StShift;
                    end else begin
                        result_d  = op_result;
                        zero_d    = (op_result == '0);
                        illegal_d = op_illegal;
                        state_d   = StDone;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            result_q  <= '0;
            zero_q    <= 1'b0;
            illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
            shreg_q   <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
            illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
`endif
        end
    end

    always_comb begin
        busy_o    = (state_q == StShift);
        done_o    = (state_q == StDone);
        result_o  = result_q;
        zero_o    = zero_q;
        illegal_o = illegal_q;
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (both shifter builds via ALU_FAST_SHIFT_EN).
module tb_alu_exec_unit;

    localparam logic [3:0] OpLui = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpSll = 4'b0010;
    localparam logic [3:0] OpAdd = 4'b0011;
    localparam logic [3:0] OpSrl = 4'b0100;
    localparam logic [3:0] OpSub = 4'b0101;
    localparam logic [3:0] OpBad = 4'b1001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [3:0]  alu_operation_i = '0;
    logic [31:0] a_data_i = '0;
    logic [31:0] b_data_i = '0;
    logic [4:0]  shamt_i = '0;
    logic [31:0] result_o;
    logic        zero_o, busy_o, done_o, illegal_o;

    int n_cmp = 0;
    int n_err = 0;
    int lat, bcnt;

    alu_exec_unit #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
        .clk             (clk),
        .reset           (reset),
        .start_i         (start_i),
        .alu_operation_i (alu_operation_i),
        .a_data_i        (a_data_i),
        .b_data_i        (b_data_i),
        .shamt_i         (shamt_i),
        .result_o        (result_o),
        .zero_o          (zero_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .illegal_o       (illegal_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one op with start for a single edge; returns sampled #1 after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh);
        alu_operation_i = op;
        a_data_i        = a;
        b_data_i        = b;
        shamt_i         = sh;
        start_i         = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    // Counts cycles until done_o and busy cycles; optionally holds an ADD request meanwhile.
    task automatic wait_done(input bit hold_add, output int cycles, output int busy_cycles);
        cycles      = 0;
        busy_cycles = 0;
        while (!done_o && cycles < 100) begin
            check("busy_done_excl", {31'b0, busy_o & done_o}, 32'd0);
            if (busy_o) busy_cycles++;
            if (hold_add) begin
                alu_operation_i = OpAdd;
                a_data_i        = 32'd1;
                b_data_i        = 32'd1;
                shamt_i         = 5'd0;
                start_i         = 1'b1;
            end
            step();
            cycles++;
        end
        start_i = 1'b0;
        check("done_seen", {31'b0, done_o}, 32'd1);
    endtask

    task automatic check_single(input string tag, input logic [31:0] res, input logic zero);
        check({tag, "_done"}, {31'b0, done_o}, 32'd1);
        check({tag, "_busy"}, {31'b0, busy_o}, 32'd0);
        check({tag, "_res"}, result_o, res);
        check({tag, "_zero"}, {31'b0, zero_o}, {31'b0, zero});
        check({tag, "_ill"}, {31'b0, illegal_o}, 32'd0);
    endtask

    initial begin
        int exp_lat_sll4, exp_lat_srl31, exp_lat_sll20;
`ifdef ALU_FAST_SHIFT_EN
        exp_lat_sll4  = 0;
        exp_lat_srl31 = 0;
        exp_lat_sll20 = 0;
`else
        exp_lat_sll4  = 4;
        exp_lat_srl31 = 31;
        exp_lat_sll20 = 20;
`endif
        #12;
        check("rst_res", result_o, 32'd0);
        check("rst_flags", {27'b0, zero_o, busy_o, done_o, illegal_o, 1'b0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();

        issue(OpAdd, 32'd7, 32'd5, 5'd0);
        check_single("add", 32'd12, 1'b0);
        step();
        check("add_pulse", {31'b0, done_o}, 32'd0);
        check("add_hold", result_o, 32'd12);

        issue(OpSub, 32'd5, 32'd5, 5'd0);
        check_single("sub", 32'd0, 1'b1);
        issue(OpAdd, 32'hFFFF_FFFF, 32'd1, 5'd0);
        check_single("wrap", 32'd0, 1'b1);
        issue(OpLui, 32'hDEAD_0000, 32'h0000_1234, 5'd0);
        check_single("lui", 32'h1234_0000, 1'b0);
        issue(OpOr, 32'h0000_00F0, 32'h0000_000F, 5'd0);
        check_single("or", 32'h0000_00FF, 1'b0);
        step();

        issue(OpSll, 32'd0, 32'd1, 5'd4);
        wait_done(1'b0, lat, bcnt);
        check("sll4_lat", lat, exp_lat_sll4);
        check("sll4_busy", bcnt, exp_lat_sll4);
        check("sll4_res", result_o, 32'h10);
        check("sll4_ill", {31'b0, illegal_o}, 32'd0);

        issue(OpSll, 32'd0, 32'hA5, 5'd0);
        wait_done(1'b0, lat, bcnt);
        check("sll0_lat", lat, 0);
        check("sll0_res", result_o, 32'hA5);
        step();

        issue(OpSrl, 32'd0, 32'h8000_0000, 5'd31);
        wait_done(1'b1, lat, bcnt);
        check("srl31_lat", lat, exp_lat_srl31);
        check("srl31_busy", bcnt, exp_lat_srl31);
        check("srl31_res", result_o, 32'h1);
        check("srl31_zero", {31'b0, zero_o}, 32'd0);
        step();
        check("srl31_hold", result_o, 32'h1);
        check("srl31_pulse", {31'b0, done_o}, 32'd0);

        alu_operation_i = OpBad;
        a_data_i        = 32'h1234;
        b_data_i        = 32'h5678;
        start_i         = 1'b1;
        step();
        check("ill_done", {31'b0, done_o}, 32'd1);
        check("ill_flag", {31'b0, illegal_o}, 32'd1);
        check("ill_res", result_o, 32'd0);
        check("ill_zero", {31'b0, zero_o}, 32'd1);
        alu_operation_i = OpAdd;
        a_data_i        = 32'd1;
        b_data_i        = 32'd1;
        step();
        start_i = 1'b0;
        check_single("b2b", 32'd2, 1'b0);

        issue(OpSll, 32'd0, 32'd3, 5'd20);
        for (int i = 0; i < 7; i++) step();
`ifndef ALU_FAST_SHIFT_EN
        check("mid_busy", {31'b0, busy_o}, 32'd1);
`endif
        reset = 1'b1;
        #1;
        check("arst_res", result_o, 32'd0);
        check("arst_flags", {28'b0, zero_o, busy_o, done_o, illegal_o}, 32'd0);
        step();
        reset = 1'b0;
        bcnt = 0;
        for (int i = 0; i < 25; i++) begin
            if (done_o || busy_o) bcnt++;
            step();
        end
        check("arst_no_done", bcnt, 0);
        issue(OpAdd, 32'd3, 32'd4, 5'd0);
        check_single("post_rst", 32'd7, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
